// File: rtl/bcd2bin_seq_if.sv
// Handshake/data bundle between the BCD input path (master) and bcd2bin_seq (slave).
interface bcd2bin_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output start, bcd, input bin, busy, done, err);
  modport slave  (input start, bcd, output bin, busy, done, err);
endinterface

// File: rtl/bcd2bin_seq.sv
// Reverse double-dabble BCD->binary, one bit per clock; done pulses WIDTH+1 cycles after accept,
// start ignored while busy (no queuing). BCD2BIN_CHECK_EN adds digit/overflow checking with saturation.
module bcd2bin_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic           clk,
  input  logic           rst,
  bcd2bin_seq_if.slave   bus
);
  localparam int BW  = 4 * DIGITS;
  localparam int SRW = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [SRW-1:0]     sr, sr_nxt, sr_sh;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   bin_q, bin_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               err_q, err_nxt;
`ifdef BCD2BIN_CHECK_EN
  logic               bad, bad_nxt, bad_in, ovf;
`endif

  // Shift right, then pull every BCD digit that reached 8+ back by 3.
  always_comb begin
    sr_sh = sr >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_sh[WIDTH+4*i +: 4] >= 4'd8)
        sr_sh[WIDTH+4*i +: 4] = sr_sh[WIDTH+4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd[4*i +: 4] > 4'd9)
        bad_in = 1'b1;
    end
  end

  // Anything left in the BCD field after the last shift means value >= 2^WIDTH.
  assign ovf = |sr_sh[SRW-1:WIDTH];
`endif

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bin_nxt   = bin_q;
    err_nxt   = err_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
`ifdef BCD2BIN_CHECK_EN
    bad_nxt   = bad;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          sr_nxt    = {bus.bcd, {WIDTH{1'b0}}};
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
`ifdef BCD2BIN_CHECK_EN
          bad_nxt   = bad_in;
`endif
        end
      end
      SHIFT: begin
        sr_nxt  = sr_sh;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
`ifdef BCD2BIN_CHECK_EN
          err_nxt   = bad | ovf;
          bin_nxt   = (bad | ovf) ? {WIDTH{1'b1}} : sr_sh[WIDTH-1:0];
`else
          err_nxt   = 1'b0;
          bin_nxt   = sr_sh[WIDTH-1:0];
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      bin_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
      bad    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      bin_q  <= bin_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
`ifdef BCD2BIN_CHECK_EN
      bad    <= bad_nxt;
`endif
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule
